user_key_input: RTL

USER_KEY_INPUT -- requirements
Module: user_key_input

---
 rtl/user_key_input.sv | 106 ++++++++++
 1 files changed

// File: rtl/user_key_input.sv
// Eight-key push-button front end: synchronize, debounce, latch press events,
// count press cycles and raise a maskable level interrupt over a 4-word register map.
module user_key_input #(
  parameter int unsigned DEBOUNCE_CYCLES = 20000,
  parameter bit          KEY_ACTIVE_LOW  = 1'b1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [7:0]  user_key,
  input  logic [1:0]  addr,
  input  logic        we,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic        irq
);

  localparam int unsigned NKEYS   = 8;
  localparam int unsigned CNT_W   = 16;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [NKEYS-1:0] KEY_IDLE = KEY_ACTIVE_LOW ? {NKEYS{1'b1}} : {NKEYS{1'b0}};

  localparam logic [1:0] ADDR_STATE = 2'd0;
  localparam logic [1:0] ADDR_EVENT = 2'd1;
  localparam logic [1:0] ADDR_IRQEN = 2'd2;
  localparam logic [1:0] ADDR_COUNT = 2'd3;

  logic [NKEYS-1:0] r_sync1;
  logic [NKEYS-1:0] r_sync2;
  logic [NKEYS-1:0] r_sample;
  logic [CNT_W-1:0] r_cnt [NKEYS];
  logic [NKEYS-1:0] r_stable;
  logic [NKEYS-1:0] r_event;
  logic [NKEYS-1:0] r_irq_en;
  logic [7:0]       r_count;
  logic             r_irq;

  logic [CNT_W-1:0] w_cnt_nxt [NKEYS];
  logic [NKEYS-1:0] w_stable_nxt;
  logic [NKEYS-1:0] w_press;
  logic [NKEYS-1:0] w_event_clr;
  logic             w_wr_count;
  logic             w_unused;

  assign w_unused = ^wdata[31:8];

  // Per-key debounce: a mismatch must persist DEBOUNCE_CYCLES cycles to be accepted
  always_comb begin
    w_stable_nxt = r_stable;
    for (int i = 0; i < NKEYS; i++) begin
      w_cnt_nxt[i] = '0;
      if (r_sample[i] != r_stable[i]) begin
        if (r_cnt[i] == CNT_LAST) begin
          w_stable_nxt[i] = r_sample[i];
        end else begin
          w_cnt_nxt[i] = CNT_W'(r_cnt[i] + CNT_W'(1));
        end
      end
    end
  end

  assign w_press     = w_stable_nxt & ~r_stable;
  assign w_event_clr = (we && (addr == ADDR_EVENT)) ? wdata[NKEYS-1:0] : '0;
  assign w_wr_count  = we && (addr == ADDR_COUNT);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_sync1  <= KEY_IDLE;
      r_sync2  <= KEY_IDLE;
      r_sample <= '0;
      for (int i = 0; i < NKEYS; i++) r_cnt[i] <= '0;
      r_stable <= '0;
      r_event  <= '0;
      r_irq_en <= '0;
      r_count  <= '0;
      r_irq    <= 1'b0;
    end else begin
      r_sync1  <= user_key;
      r_sync2  <= r_sync1;
      r_sample <= r_sync2 ^ KEY_IDLE;
      for (int i = 0; i < NKEYS; i++) r_cnt[i] <= w_cnt_nxt[i];
      r_stable <= w_stable_nxt;
      // New press wins over a same-cycle W1C clear
      r_event  <= (r_event & ~w_event_clr) | w_press;
      if (we && (addr == ADDR_IRQEN)) r_irq_en <= wdata[NKEYS-1:0];
      if (w_wr_count) begin
        r_count <= (|w_press) ? 8'd1 : 8'd0;
      end else if ((|w_press) && (r_count != 8'hFF)) begin
        r_count <= 8'(r_count + 8'd1);
      end
      r_irq    <= |(r_event & r_irq_en);
    end
  end

  always_comb begin
    rdata = '0;
    case (addr)
      ADDR_STATE: rdata = {24'b0, r_stable};
      ADDR_EVENT: rdata = {24'b0, r_event};
      ADDR_IRQEN: rdata = {24'b0, r_irq_en};
      default:    rdata = {24'b0, r_count};
    endcase
  end

  assign irq = r_irq;

endmodule
